// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart block and its helpers.
//   OVERSAMPLING_RATE  : receiver oversampling factor per bit period
//   DATA_BITS_DEFAULT  : default character width
//   STATE_*            : transmit-feeder FSM encodings
//   tx_feed_state_e    : enum used by uart_tx_fifo for its drain FSM
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLING_RATE = 16;
    localparam int DATA_BITS_DEFAULT = 8;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_START = STATE_START,
        ST_DRAIN = STATE_DRAIN
    } tx_feed_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for bringing a level signal from another
// clock domain into the clk domain. Both stages reset to zero.
//   clk      : destination clock
//   nrst_in  : asynchronous active-low reset
//   i_data   : asynchronous input level(s)
//   o_data   : synchronised copy, two clk edges behind i_data
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst_in,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a full cycle
    // to settle before anything downstream looks at it.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
        end
    end

    assign o_data = r_sync;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Transmit buffer sitting in front of the uart TX path. Producers push bytes
// through a valid/ready port into a circular FIFO; a small FSM hands them to
// the serialiser one at a time, pacing on the serialiser's busy flag.
//   clk           : system clock (same clock as uart clk)
//   nrst_in       : asynchronous active-low reset
//   wr_data_in    : byte to enqueue
//   wr_valid_in   : write request, accepted when wr_ready_out is high
//   wr_ready_out  : FIFO not full
//   level_out     : number of stored entries, 0..DEPTH
//   empty_out     : FIFO empty
//   overflow_out  : one-cycle pulse after a write attempted while full
//   tx_data_out   : to uart tx_data_in
//   tx_start_out  : to uart data_rdy_in
//   tx_busy_in    : from uart tx_busy_out (may be in the baud domain)
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int DEPTH     = 16
) (
    input  logic                  clk,
    input  logic                  nrst_in,
    input  logic [DATA_BITS-1:0]  wr_data_in,
    input  logic                  wr_valid_in,
    output logic                  wr_ready_out,
    output logic [$clog2(DEPTH):0] level_out,
    output logic                  empty_out,
    output logic                  overflow_out,
    output logic [DATA_BITS-1:0]  tx_data_out,
    output logic                  tx_start_out,
    input  logic                  tx_busy_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [PTR_W:0]       r_level;
    logic                 r_overflow;
    logic [DATA_BITS-1:0] r_txData;
    logic                 r_txStart;
    tx_feed_state_e       r_state;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_busySync;

    // Full is judged on the registered level only, so a write arriving while
    // full is refused even if a byte leaves on the same edge.
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_empty = (r_level == '0);
    assign w_push  = wr_valid_in && !w_full;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;

    sync_2ff #(
        .WIDTH (1)
    ) u_busySync (
        .clk     (clk),
        .nrst_in (nrst_in),
        .i_data  (tx_busy_in),
        .o_data  (w_busySync)
    );

    // Storage is deliberately left unreset; the level counter decides what
    // is valid, so stale contents are never read out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data_in;
        end
    end

    // Pointers wrap naturally at DEPTH. The level counter is kept separately
    // so full and empty need no extra wrap bit on the pointers.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            r_overflow <= wr_valid_in && w_full;
        end
    end

    // Drain FSM. tx_start is held until the serialiser reports busy so the
    // slower baud-domain logic is sure to see it, then dropped well before
    // the character finishes so exactly one character goes out per pop.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            r_state   <= ST_IDLE;
            r_txData  <= '0;
            r_txStart <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_txData  <= r_mem[r_rdPtr];
                        r_txStart <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_busySync) begin
                        r_txStart <= 1'b0;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_busySync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_txStart <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready_out = !w_full;
    assign level_out    = r_level;
    assign empty_out    = w_empty;
    assign overflow_out = r_overflow;
    assign tx_data_out  = r_txData;
    assign tx_start_out = r_txStart;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A behavioural serialiser model
// consumes tx_start/tx_data and drives busy; a queue-based FIFO model
// predicts level, flags and the order of bytes leaving the buffer.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;

    logic                 clk = 1'b0;
    logic                 nrst_in;
    logic [DATA_BITS-1:0] wr_data_in;
    logic                 wr_valid_in;
    logic                 wr_ready_out;
    logic [4:0]           level_out;
    logic                 empty_out;
    logic                 overflow_out;
    logic [DATA_BITS-1:0] tx_data_out;
    logic                 tx_start_out;
    logic                 tx_busy_in;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // FIFO reference model state
    int         modelCount;
    logic [7:0] expQ[$];
    logic [7:0] acceptedLog[$];
    logic       prevStart;
    int         popCount;
    int         overflowSeen;
    int         maxLevel;

    // Serialiser model state; only the model process writes these
    logic       uBusy = 1'b0;
    int         uPhase = 0;
    int         uCnt = 0;
    int         uViolations = 0;
    logic [7:0] rxLog[$];
    int         rxBase = 0;

    // Serialiser model configuration; only the stimulus process writes these
    logic       uartEnable = 1'b0;
    logic       holdBusy = 1'b0;
    logic       cfgRandom = 1'b0;
    int         cfgDelay = 10;
    int         cfgHold = 100;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       busy;
        logic [4:0] expLevel;
        logic       expStart;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[11];

    assign tx_busy_in = uBusy | holdBusy;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .nrst_in      (nrst_in),
        .wr_data_in   (wr_data_in),
        .wr_valid_in  (wr_valid_in),
        .wr_ready_out (wr_ready_out),
        .level_out    (level_out),
        .empty_out    (empty_out),
        .overflow_out (overflow_out),
        .tx_data_out  (tx_data_out),
        .tx_start_out (tx_start_out),
        .tx_busy_in   (tx_busy_in)
    );

    // Behavioural serialiser: on seeing data_rdy while idle it captures the
    // byte, raises busy after a start delay, holds it for the character time
    // and then drops it. data_rdy still high at the end counts as a violation.
    always @(negedge clk) begin
        if (uartEnable) begin
            case (uPhase)
                0: begin
                    if (tx_start_out) begin
                        rxLog.push_back(tx_data_out);
                        uCnt   = cfgRandom ? int'($urandom_range(1, 4)) : cfgDelay;
                        uPhase = 1;
                    end
                end
                1: begin
                    uCnt = uCnt - 1;
                    if (uCnt <= 0) begin
                        uBusy  = 1'b1;
                        uCnt   = cfgRandom ? int'($urandom_range(5, 10)) : cfgHold;
                        uPhase = 2;
                    end
                end
                default: begin
                    uCnt = uCnt - 1;
                    if (uCnt <= 0) begin
                        uBusy  = 1'b0;
                        uPhase = 0;
                        if (tx_start_out) begin
                            uViolations = uViolations + 1;
                        end
                    end
                end
            endcase
        end
    end

    function automatic int rxCount();
        return rxLog.size() - rxBase;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic clearLogs();
        acceptedLog.delete();
        rxBase       = rxLog.size();
        popCount     = 0;
        overflowSeen = 0;
        maxLevel     = 0;
    endtask

    task automatic resetModel();
        modelCount = 0;
        expQ.delete();
        prevStart = 1'b0;
        clearLogs();
    endtask

    // One clock of stimulus followed by a comparison against the FIFO model.
    // A pop is observed as a rising tx_start; a write is accepted only when
    // the model held fewer than DEPTH entries before the edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        logic preFull;
        logic accept;
        logic popped;
        wr_valid_in = valid;
        wr_data_in  = data;
        preFull = (modelCount >= DEPTH);
        accept  = valid && !preFull;
        @(posedge clk);
        #1;
        popped    = tx_start_out && !prevStart;
        prevStart = tx_start_out;
        if (popped) begin
            popCount++;
            checkOutput("popNotEmpty", 32'(modelCount != 0), 32'd1);
            if (modelCount != 0) begin
                checkOutput("popData", 32'(tx_data_out), 32'(expQ[0]));
                void'(expQ.pop_front());
                modelCount--;
            end
        end
        if (accept) begin
            expQ.push_back(data);
            acceptedLog.push_back(data);
            modelCount++;
        end
        if (overflow_out) overflowSeen++;
        if (int'(level_out) > maxLevel) maxLevel = int'(level_out);
        checkOutput("level", 32'(level_out), 32'(modelCount));
        checkOutput("empty", 32'(empty_out), 32'(modelCount == 0));
        checkOutput("wrReady", 32'(wr_ready_out), 32'(modelCount < DEPTH));
        checkOutput("overflow", 32'(overflow_out), 32'(valid && preFull));
    endtask

    task automatic applyReset();
        nrst_in     = 1'b0;
        wr_valid_in = 1'b0;
        wr_data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstLevel", 32'(level_out), 32'd0);
        checkOutput("rstEmpty", 32'(empty_out), 32'd1);
        checkOutput("rstReady", 32'(wr_ready_out), 32'd1);
        checkOutput("rstStart", 32'(tx_start_out), 32'd0);
        checkOutput("rstOverflow", 32'(overflow_out), 32'd0);
        checkOutput("rstTxData", 32'(tx_data_out), 32'd0);
        @(negedge clk);
        nrst_in = 1'b1;
        resetModel();
    endtask

    task automatic drainAll(input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            applyStimulus(1'b0, 8'h00);
            n++;
            done = (modelCount == 0) && (uPhase == 0) && (rxCount() == acceptedLog.size());
        end
        repeat (4) applyStimulus(1'b0, 8'h00);
        checkOutput("drainDone", 32'(done), 32'd1);
    endtask

    task automatic compareLogs();
        checkOutput("rxCount", 32'(rxCount()), 32'(acceptedLog.size()));
        for (int i = 0; i < rxCount() && i < acceptedLog.size(); i++) begin
            checkOutput("rxOrder", 32'(rxLog[rxBase + i]), 32'(acceptedLog[i]));
        end
        checkOutput("startsPerByte", 32'(popCount), 32'(acceptedLog.size()));
    endtask

    // Test sequence
    initial begin
        int eeCount;
        int guard;

        // Single-byte latency table with busy driven directly
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'hA5};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'hA5};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'hA5};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5};
        vecs[9]  = '{1'b1, 8'h5A, 1'b0, 5'd1, 1'b0, 8'hA5};
        vecs[10] = '{1'b1 & 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'h5A};

        applyReset();

        for (int i = 0; i < 11; i++) begin
            wr_valid_in = vecs[i].valid;
            wr_data_in  = vecs[i].data;
            holdBusy    = vecs[i].busy;
            @(posedge clk);
            #1;
            checkOutput("vecLevel", 32'(level_out), 32'(vecs[i].expLevel));
            checkOutput("vecEmpty", 32'(empty_out), 32'(vecs[i].expLevel == 5'd0));
            checkOutput("vecStart", 32'(tx_start_out), 32'(vecs[i].expStart));
            checkOutput("vecData", 32'(tx_data_out), 32'(vecs[i].expData));
        end
        wr_valid_in = 1'b0;
        holdBusy    = 1'b0;

        // Ordering: five back-to-back bytes through the serialiser model
        applyReset();
        uartEnable = 1'b1;
        cfgRandom  = 1'b0;
        cfgDelay   = 10;
        cfgHold    = 100;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i));
        end
        drainAll(2000);
        checkOutput("orderCount", 32'(rxCount()), 32'd5);
        for (int i = 0; i < rxCount() && i < 5; i++) begin
            checkOutput("orderByte", 32'(rxLog[rxBase + i]), 32'(i + 1));
        end
        compareLogs();

        // Full and overflow: one byte parked in flight, then DEPTH+1 writes
        clearLogs();
        cfgDelay = 2;
        cfgHold  = 6;
        holdBusy = 1'b1;
        applyStimulus(1'b1, 8'h80);
        repeat (6) applyStimulus(1'b0, 8'h00);
        checkOutput("parkedStartLow", 32'(tx_start_out), 32'd0);
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b1, (i == DEPTH) ? 8'hEE : 8'(8'h90 + i));
        end
        checkOutput("fullLevel", 32'(level_out), 32'(DEPTH));
        checkOutput("fullReady", 32'(wr_ready_out), 32'd0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("overflowPulses", 32'(overflowSeen), 32'd1);
        holdBusy = 1'b0;
        drainAll(4000);
        compareLogs();
        eeCount = 0;
        for (int i = 0; i < rxCount(); i++) begin
            if (rxLog[rxBase + i] == 8'hEE) eeCount++;
        end
        checkOutput("droppedByteSent", 32'(eeCount), 32'd0);
        checkOutput("fullRxCount", 32'(rxCount()), 32'(DEPTH + 1));

        // Wrap-around: 40 random writes interleaved with random idles
        clearLogs();
        cfgRandom = 1'b1;
        guard     = 0;
        while (acceptedLog.size() < 40 && guard < 4000) begin
            applyStimulus($urandom_range(0, 2) != 0, 8'($urandom));
            guard++;
        end
        checkOutput("randAccepted", 32'(acceptedLog.size()), 32'd40);
        drainAll(4000);
        compareLogs();
        checkOutput("levelBound", 32'(maxLevel <= DEPTH), 32'd1);

        // Reset in the middle of a hand-off
        clearLogs();
        cfgRandom = 1'b0;
        cfgDelay  = 50;
        cfgHold   = 10;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h31 + i));
        end
        checkOutput("preRstLevel", 32'(level_out), 32'd3);
        checkOutput("preRstStart", 32'(tx_start_out), 32'd1);
        #2;
        nrst_in = 1'b0;
        #1;
        checkOutput("midRstStart", 32'(tx_start_out), 32'd0);
        checkOutput("midRstLevel", 32'(level_out), 32'd0);
        checkOutput("midRstEmpty", 32'(empty_out), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst_in = 1'b1;
        resetModel();
        repeat (100) applyStimulus(1'b0, 8'h00);
        checkOutput("startsAfterRst", 32'(popCount), 32'd0);
        checkOutput("rxAfterRst", 32'(rxCount()), 32'd0);
        checkOutput("startHeldPastBusy", 32'(uViolations), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
